// File: rtl/kim1_display_keypad.sv
// kim1_display_keypad: RRIOT port-pin peripheral that latches scanned 7-segment digits
// and returns debounced keypad columns plus synchronised TTY input on PAI.
module kim1_display_keypad #(
    parameter int SETTLE_CYC = 4,
    parameter int TICK_DIV   = 1000,
    parameter int PERSIST    = 255
) (
    input  logic        phi2,
    input  logic        rst_n,
    input  logic [7:0]  pao,
    input  logic [7:0]  ddra,
    input  logic [7:0]  pbo,
    input  logic [7:0]  ddrb,
    input  logic [20:0] key_raw,
    input  logic        tty_rx,
    output logic [7:0]  pai,
    output logic [41:0] seg,
    output logic [5:0]  digit_on,
    output logic        key_any
);
    localparam int SW = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [3:0]    sel, sel_q;
    logic [SW-1:0] settle;
    logic [TW-1:0] tcnt;
    logic          tick, cap;
    logic [2:0]    dig;
    logic [6:0]    row;
    logic [20:0]   key_s1, key_s2, hist0, hist1, deb;
    logic          tty_s1, tty_s2;
    logic [7:0]    persist [6];
    logic          unused;

    assign unused = ^{pao[7], ddra[7], pbo[7:5], pbo[0], ddrb[7:5], ddrb[0]};

    always_comb begin
        sel  = (ddrb[4:1] == 4'hF) ? pbo[4:1] : 4'hF;
        tick = (tcnt == TW'(TICK_DIV - 1));
        // 3-bit wrap maps selects 4..9 onto digits 0..5
        dig  = sel[2:0] - 3'd4;
        cap  = (sel == sel_q) && (sel >= 4'd4) && (sel <= 4'd9) && (&ddra[6:0])
               && (settle == SW'(SETTLE_CYC));
        row  = (sel_q == 4'd0) ? ~deb[6:0] :
               (sel_q == 4'd1) ? ~deb[13:7] :
               (sel_q == 4'd2) ? ~deb[20:14] : 7'h7F;
    end

    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            sel_q    <= '0;
            settle   <= '0;
            tcnt     <= '0;
            key_s1   <= '0;
            key_s2   <= '0;
            hist0    <= '0;
            hist1    <= '0;
            deb      <= '0;
            tty_s1   <= 1'b1;
            tty_s2   <= 1'b1;
            pai      <= 8'hFF;
            seg      <= '0;
            digit_on <= '0;
            key_any  <= 1'b0;
            for (int d = 0; d < 6; d++) persist[d] <= '0;
        end else begin
            sel_q   <= sel;
            settle  <= (sel != sel_q) ? '0 :
                       (settle == SW'(SETTLE_CYC)) ? settle : settle + 1'b1;
            tcnt    <= tick ? '0 : tcnt + 1'b1;
            key_s1  <= key_raw;
            key_s2  <= key_s1;
            tty_s1  <= tty_rx;
            tty_s2  <= tty_s1;
            if (tick) begin
                hist0 <= key_s2;
                hist1 <= hist0;
                // set on three ones, clear on three zeros, otherwise hold
                deb   <= (deb | (hist1 & hist0 & key_s2)) & (hist1 | hist0 | key_s2);
            end
            for (int d = 0; d < 6; d++) begin
                if (cap && dig == 3'(d)) begin
                    seg[d*7 +: 7] <= pao[6:0];
                    persist[d]    <= 8'(PERSIST);
                    digit_on[d]   <= 1'b1;
                end else if (tick && persist[d] != 8'd0) begin
                    persist[d] <= persist[d] - 8'd1;
                    if (persist[d] == 8'd1) digit_on[d] <= 1'b0;
                end
            end
            pai     <= {tty_s2, row};
            key_any <= |deb;
        end
    end
endmodule
